// File: rtl/oc8051_rom_arb.sv
// oc8051_rom_arb: program-memory arbiter sharing one read path between 3-byte fetch (i_*) and 1-byte MOVC (d_*)
//   clk/rst            clock, async active-high reset
//   i_req/i_addr       fetch request/address -> i_ack pulse, i_data {b2,b1,b0}
//   d_req/d_addr       MOVC request/address  -> d_ack pulse, d_data
//   rom_addr/rom_data* internal ROM, data one cycle after address
//   ext_*              external byte bus, strobe held until ext_ack
module oc8051_rom_arb #(
  parameter int INT_ROM_WID = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ack,
  output logic [23:0] i_data,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  output logic        d_ack,
  output logic [7:0]  d_data,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data1,
  input  logic [7:0]  rom_data2,
  input  logic [7:0]  rom_data3,
  output logic [15:0] ext_addr,
  output logic        ext_stb,
  input  logic        ext_ack,
  input  logic [7:0]  ext_data
);
  typedef enum logic [2:0] {IDLE, ROM_A, ROM_D, EXT, EXT_GAP, DONE} state_t;
  state_t r_state, w_next;
  logic r_gnt_i, r_last_i;
  logic [15:0] r_base, r_buf;
  logic [1:0] r_cnt;
  logic w_req, w_sel_i, w_ext, w_last_byte;
  logic [15:0] w_addr;
  assign w_req = i_req | d_req;
  // round-robin: on conflict the fetch wins only if MOVC was granted last
  assign w_sel_i = i_req & (~d_req | ~r_last_i);
  assign w_addr = w_sel_i ? i_addr : d_addr;
  assign w_ext = |w_addr[15:INT_ROM_WID];
  assign w_last_byte = r_cnt == (r_gnt_i ? 2'd2 : 2'd0);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_req ? (w_ext ? EXT : ROM_A) : IDLE;
      ROM_A:   w_next = ROM_D;
      ROM_D:   w_next = DONE;
      EXT:     w_next = ext_ack ? (w_last_byte ? DONE : EXT_GAP) : EXT;
      EXT_GAP: w_next = EXT;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      i_data   <= 24'd0;
      d_data   <= 8'd0;
      rom_addr <= 16'd0;
      ext_addr <= 16'd0;
      ext_stb  <= 1'b0;
      r_gnt_i  <= 1'b0;
      r_last_i <= 1'b0;
      r_base   <= 16'd0;
      r_buf    <= 16'd0;
      r_cnt    <= 2'd0;
    end else begin
      i_ack <= r_state == DONE && r_gnt_i;
      d_ack <= r_state == DONE && !r_gnt_i;
      case (r_state)
        IDLE: if (w_req) begin
          r_gnt_i  <= w_sel_i;
          r_last_i <= w_sel_i;
          r_base   <= w_addr;
          if (w_ext) begin
            ext_addr <= w_addr;
            ext_stb  <= 1'b1;
            r_cnt    <= 2'd0;
          end else rom_addr <= w_addr;
        end
        ROM_D: if (r_gnt_i) i_data <= {rom_data3, rom_data2, rom_data1};
               else d_data <= rom_data1;
        // early fetch bytes are staged so i_data only changes when the fetch completes
        EXT: if (ext_ack) begin
          ext_stb <= 1'b0;
          if (w_last_byte) begin
            if (r_gnt_i) i_data <= {ext_data, r_buf};
            else d_data <= ext_data;
          end else begin
            r_buf[{r_cnt[0], 3'b000} +: 8] <= ext_data;
            r_cnt    <= r_cnt + 2'd1;
            ext_addr <= r_base + {14'd0, r_cnt} + 16'd1;
          end
        end
        EXT_GAP: ext_stb <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_oc8051_rom_arb.sv
// tb_oc8051_rom_arb: transaction-level model plus directed scenarios for oc8051_rom_arb
module tb_oc8051_rom_arb;
  logic clk = 0, rst = 1;
  logic i_req = 0, d_req = 0, i_ack, d_ack, ext_stb, ext_ack;
  logic [15:0] i_addr = 0, d_addr = 0, rom_addr, ext_addr;
  logic [23:0] i_data;
  logic [7:0] d_data, rom_data1, rom_data2, rom_data3, ext_data;
  int n_tests = 0, n_fail = 0, ext_dly = 0, wcnt = 0;

  oc8051_rom_arb dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
    .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_data(d_data),
    .rom_addr(rom_addr), .rom_data1(rom_data1), .rom_data2(rom_data2), .rom_data3(rom_data3),
    .ext_addr(ext_addr), .ext_stb(ext_stb), .ext_ack(ext_ack), .ext_data(ext_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    case (a)
      16'h0010: return 8'h12;
      16'h0011: return 8'h34;
      16'h0012: return 8'h56;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] ext_byte(input logic [15:0] a);
    case (a)
      16'hFFFE: return 8'h11;
      16'hFFFF: return 8'h22;
      16'h0000: return 8'h33;
      16'h8005: return 8'hA5;
      default:  return a[15:8] ^ a[7:0] ^ 8'hC3;
    endcase
  endfunction

  function automatic logic [7:0] mem(input logic ext, input logic [15:0] a);
    return ext ? ext_byte(a) : rom_byte(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(posedge clk) begin
    rom_data1 <= rom_byte(rom_addr);
    rom_data2 <= rom_byte(rom_addr + 16'd1);
    rom_data3 <= rom_byte(rom_addr + 16'd2);
  end

  always @(posedge clk or posedge rst)
    if (rst) begin
      ext_ack <= 0;
      ext_data <= 0;
      wcnt <= 0;
    end else if (ext_stb && !ext_ack) begin
      if (wcnt >= ext_dly) begin
        ext_ack <= 1;
        ext_data <= ext_byte(ext_addr);
        wcnt <= 0;
      end else wcnt <= wcnt + 1;
    end else ext_ack <= 0;

  logic m_busy = 0, m_last = 0, m_who = 0, m_ext = 0, p_i = 0, p_d = 0;
  logic [15:0] m_addr = 0, p_ia = 0, p_da = 0;
  int m_t = 0;

  // inputs seen at the previous negedge are the ones the DUT saw at the edge in between
  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_last = 0; p_i = 0; p_d = 0;
    end else begin
      if (!m_busy && (p_i || p_d)) begin
        m_who = p_i && (!p_d || !m_last);
        m_last = m_who;
        m_addr = m_who ? p_ia : p_da;
        m_ext = m_addr[15];
        m_busy = 1;
        m_t = 0;
        if (!m_ext) chk("model_rom_addr", rom_addr, m_addr);
      end else if (m_busy) m_t++;
      chk("ack_excl", i_ack & d_ack, 0);
      if (i_ack || d_ack) begin
        if (!m_busy) chk("spurious_ack", {i_ack, d_ack}, 0);
        else begin
          chk("ack_who", {i_ack, d_ack}, m_who ? 2 : 1);
          if (m_who) chk("model_i_data", i_data, {8'd0, mem(m_ext, m_addr + 16'd2), mem(m_ext, m_addr + 16'd1), mem(m_ext, m_addr)});
          else chk("model_d_data", d_data, mem(m_ext, m_addr));
          if (!m_ext) chk("int_latency", m_t, 3);
          m_busy = 0;
        end
      end else if (m_busy && m_t > (m_ext ? 300 : 3)) begin
        chk("ack_timeout", m_t, m_ext ? 300 : 3);
        m_busy = 0;
      end
      p_i = i_req; p_d = d_req; p_ia = i_addr; p_da = d_addr;
    end
  end

  task automatic wait_any(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(i_ack || d_ack) && n < 500);
    if (!(i_ack || d_ack)) chk("ack_wait", {i_ack, d_ack}, 3);
  endtask

  initial begin
    int n, stb_n, k, lowrun;
    logic pstb, seen;
    logic [15:0] r0;
    logic [15:0] exp_a [3];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_i_data", i_data, 0);
    chk("rst_d_data", d_data, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_ext_addr", ext_addr, 0);
    chk("rst_ext_stb", ext_stb, 0);
    rst = 0;

    @(posedge clk); #1;
    i_addr = 16'h0010; i_req = 1;
    wait_any(n);
    chk("int_fetch_who", {i_ack, d_ack}, 2);
    chk("int_fetch_data", i_data, 24'h563412);
    chk("int_fetch_cycles", n, 4);
    i_req = 0;
    repeat (2) @(posedge clk);

    #1 rst = 1;
    i_addr = 16'h0020; d_addr = 16'h0030; i_req = 1; d_req = 1;
    @(posedge clk); #1 rst = 0;
    for (int j = 0; j < 6; j++) begin
      wait_any(n);
      chk($sformatf("rr_order%0d", j), {i_ack, d_ack}, (j % 2 == 0) ? 2 : 1);
      if (j == 5) begin i_req = 0; d_req = 0; end
    end
    chk("rr_i_data", i_data, 24'h787B7A);
    chk("rr_d_data", d_data, 8'h6A);
    repeat (2) @(posedge clk);

    #1 r0 = rom_addr; ext_dly = 2; d_addr = 16'h8005; d_req = 1;
    n = 0; stb_n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (ext_stb) begin
        stb_n++;
        if (stb_n == 1) chk("movc_ext_addr", ext_addr, 16'h8005);
      end
    end while (!d_ack && n < 100);
    d_req = 0;
    chk("movc_ack", {i_ack, d_ack}, 1);
    chk("movc_data", d_data, 8'hA5);
    chk("movc_stb_cycles", stb_n, 4);
    chk("movc_rom_addr", rom_addr, r0);
    repeat (2) @(posedge clk);

    #1 ext_dly = 0; i_addr = 16'hFFFE; i_req = 1;
    n = 0; k = 0; lowrun = 0; pstb = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (ext_stb && !pstb) begin
        if (k < 3) chk($sformatf("wrap_addr%0d", k), ext_addr, exp_a[k]);
        if (k > 0) chk($sformatf("wrap_gap%0d", k), lowrun, 1);
        k++;
        lowrun = 0;
      end else if (!ext_stb && k > 0) lowrun++;
      pstb = ext_stb;
    end while (!i_ack && n < 100);
    i_req = 0;
    chk("wrap_bytes", k, 3);
    chk("wrap_data", i_data, 24'h332211);
    repeat (2) @(posedge clk);

    #1 ext_dly = 20; i_addr = 16'h8100; i_req = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ext_stb && n < 20);
    chk("mid_stb_up", ext_stb, 1);
    d_addr = 16'h0040; d_req = 1;
    @(posedge clk); #3 rst = 1;
    #1;
    chk("mid_ext_stb", ext_stb, 0);
    chk("mid_i_ack", i_ack, 0);
    chk("mid_d_ack", d_ack, 0);
    chk("mid_i_data", i_data, 0);
    chk("mid_d_data", d_data, 0);
    chk("mid_ext_addr", ext_addr, 0);
    @(posedge clk); #1 ext_dly = 1;
    @(posedge clk); #1 rst = 0;
    wait_any(n);
    chk("post_rst_first", {i_ack, d_ack}, 2);
    chk("post_rst_i_data", i_data, 24'h404342);
    i_req = 0;
    wait_any(n);
    chk("post_rst_second", {i_ack, d_ack}, 1);
    chk("post_rst_d_data", d_data, 8'h1A);
    d_req = 0;
    repeat (2) @(posedge clk);

    #1 i_addr = 16'h7FFF; i_req = 1;
    n = 0; seen = 0;
    do begin
      @(posedge clk); #1;
      n++;
      seen |= ext_stb;
      if (n == 1) chk("straddle_rom_addr", rom_addr, 16'h7FFF);
    end while (!i_ack && n < 100);
    i_req = 0;
    chk("straddle_stb", seen, 0);
    chk("straddle_data", i_data, 24'h5B5AA5);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failed so far %0d", n_fail);
    $fatal(1);
  end
endmodule
